// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and constants for the fetch/data memory arbiter.
package mem_port_arbiter_pkg;

  localparam int LAT_CNT_W       = 4;
  localparam int MEM_LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_t;

  // Keep the latency compare value inside the counter's legal range 1..MEM_LATENCY_MAX.
  function automatic logic [LAT_CNT_W-1:0] lat_clamp(input int lat);
    if (lat < 1) begin
      return LAT_CNT_W'(1);
    end else if (lat > MEM_LATENCY_MAX) begin
      return LAT_CNT_W'(MEM_LATENCY_MAX);
    end else begin
      return LAT_CNT_W'(lat);
    end
  endfunction

endpackage

// File: rtl/mem_port_ibuf.sv
// mem_port_ibuf: one-entry fetch buffer {valid, word tag, data}.
// Only built when MEM_PORT_ARBITER_IBUF_EN is defined.
`ifdef MEM_PORT_ARBITER_IBUF_EN
module mem_port_ibuf
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inv_en,
  input  logic [TAG_W-1:0]  inv_tag,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  logic              valid_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [DATA_W-1:0] data_reg;

  // Valid bit: cleared by reset or a store to the buffered word, set on every fetch fill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= 1'b0;
    end else if (inv_en && (inv_tag == tag_reg)) begin
      valid_reg <= 1'b0;
    end else if (fill_en) begin
      valid_reg <= 1'b1;
    end
  end

  // Tag and data payload; meaningless while valid is low, so no reset needed.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_reg  <= fill_tag;
      data_reg <= fill_data;
    end
  end

  assign hit      = valid_reg && (lookup_tag == tag_reg);
  assign hit_data = data_reg;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises the core's fetch and load/store ports onto one
// single-ported RAM with a fixed read latency. Data wins over fetch.
// Optional fetch buffer: define MEM_PORT_ARBITER_IBUF_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam logic [LAT_CNT_W-1:0] LAT = lat_clamp(MEM_LATENCY);

  state_t                 state_reg, state_next;
  owner_t                 owner_reg, owner_next;
  logic [LAT_CNT_W-1:0]   cnt_reg, cnt_next;
  logic                   we_reg, we_next;
  logic [DATA_W-1:0]      if_rdata_reg;
  logic [DATA_W-1:0]      d_rdata_reg;

  logic                   grant;
  logic                   grant_data;
  logic                   capture;
  logic                   hit_take;
  logic                   ibuf_hit;
  logic [DATA_W-1:0]      ibuf_data;

`ifdef MEM_PORT_ARBITER_IBUF_EN
  logic [ADDR_W-3:0]      fetch_tag_reg;

  // Remember which word the in-flight fetch targets so the buffer is filled with the right tag.
  always_ff @(posedge clk) begin
    if (grant && !grant_data) begin
      fetch_tag_reg <= if_addr[ADDR_W-1:2];
    end
  end

  mem_port_ibuf #(
    .DATA_W (DATA_W),
    .TAG_W  (ADDR_W - 2)
  ) u_ibuf (
    .clk        (clk),
    .rst        (rst),
    .fill_en    (capture && (owner_reg == FETCH)),
    .fill_tag   (fetch_tag_reg),
    .fill_data  (mem_rdata),
    .inv_en     (grant_data && d_we),
    .inv_tag    (d_addr[ADDR_W-1:2]),
    .lookup_tag (if_addr[ADDR_W-1:2]),
    .hit        (ibuf_hit),
    .hit_data   (ibuf_data)
  );
`else
  assign ibuf_hit  = 1'b0;
  assign ibuf_data = '0;
`endif

  // Next-state: grant in IDLE (data first), count latency in BUSY, one ready cycle in DONE.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    we_next    = we_reg;
    grant      = 1'b0;
    grant_data = 1'b0;
    capture    = 1'b0;
    hit_take   = 1'b0;
    case (state_reg)
      IDLE: begin
        // No grant while reset is asserted, so mem_en stays low through reset.
        if (rst) begin
          if (d_req) begin
            grant      = 1'b1;
            grant_data = 1'b1;
            owner_next = DATA;
            we_next    = d_we;
            cnt_next   = LAT_CNT_W'(1);
            state_next = BUSY;
          end else if (if_req) begin
            owner_next = FETCH;
            we_next    = 1'b0;
            if (ibuf_hit) begin
              hit_take   = 1'b1;
              state_next = DONE;
            end else begin
              grant      = 1'b1;
              cnt_next   = LAT_CNT_W'(1);
              state_next = BUSY;
            end
          end
        end
      end
      BUSY: begin
        if (cnt_reg == LAT) begin
          capture    = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + LAT_CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      owner_reg <= FETCH;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      we_reg    <= we_next;
    end
  end

  // Read-data registers: only the owner's register loads; stores leave d_rdata untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      if (hit_take) begin
        if_rdata_reg <= ibuf_data;
      end else if (capture && (owner_reg == FETCH)) begin
        if_rdata_reg <= mem_rdata;
      end
      if (capture && (owner_reg == DATA) && !we_reg) begin
        d_rdata_reg <= mem_rdata;
      end
    end
  end

  assign mem_en    = grant;
  assign mem_we    = grant_data & d_we;
  assign mem_addr  = d_req ? d_addr : if_addr;
  assign mem_wdata = d_wdata;

  assign if_ready  = (state_reg == DONE) && (owner_reg == FETCH);
  assign d_ready   = (state_reg == DONE) && (owner_reg == DATA);
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;

  assign stall     = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench running the same scenarios against two
// arbiters (MEM_LATENCY 1 and 3), each with its own latency-accurate RAM model.
module tb_mem_port_arbiter;

  localparam logic [31:0] POISON = 32'hBADB_AD00;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] base_word(input logic [7:0] idx);
    case (idx)
      8'd1:    return 32'h2008_0005;
      8'd2:    return 32'h0000_1111;
      8'd3:    return 32'h3333_3333;
      8'd16:   return 32'hDEAD_BEEF;
      default: return 32'hC0DE_0000 | {24'h0, idx};
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_lat
    localparam int LAT = (gi == 0) ? 1 : 3;

    logic        rst, if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, d_ready, mem_en, mem_we, stall;
    int          cyc = 0;
    logic        fin = 1'b0;
    exp_t        if_q[$];
    exp_t        d_q[$];
    exp_t        e;
    logic [31:0] last_load;
    int          n;

    mem_port_arbiter #(
      .MEM_LATENCY (LAT),
      .DATA_W      (32),
      .ADDR_W      (32)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ready  (if_ready),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ready   (d_ready),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall     (stall)
    );

    // RAM model: writes overlay a fixed image; read data appears LAT cycles after mem_en.
    logic [31:0]  wmem [0:255];
    logic [255:0] wvalid = '0;
    logic [31:0]  rpipe [0:LAT-1];
    logic [7:0]   ridx;
    assign ridx      = mem_addr[9:2];
    assign mem_rdata = rpipe[LAT-1];

    always @(posedge clk) begin
      if (mem_en && mem_we) begin
        wmem[ridx]   <= mem_wdata;
        wvalid[ridx] <= 1'b1;
      end
      rpipe[0] <= (mem_en && !mem_we) ? (wvalid[ridx] ? wmem[ridx] : base_word(ridx)) : POISON;
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic ck(input string t, input logic [31:0] o, input logic [31:0] x);
      check($sformatf("L%0d_%s", LAT, t), o, x);
    endtask

    // Scoreboard: every ready pulse must match the oldest expectation for that port.
    always @(negedge clk) begin
      if (if_ready) begin
        if (if_q.size() == 0) begin
          ck("if_spurious_ready", 32'(if_ready), 32'd0);
        end else begin
          e = if_q.pop_front();
          ck("if_rdata", if_rdata, e.data);
          ck("if_ready_cycle", 32'(cyc), 32'(e.cyc));
          $display("[TB] L%0d fetch done  cyc=%0d rdata=%h (exp %h @%0d)", LAT, cyc, if_rdata, e.data, e.cyc);
        end
      end
      if (d_ready) begin
        if (d_q.size() == 0) begin
          ck("d_spurious_ready", 32'(d_ready), 32'd0);
        end else begin
          e = d_q.pop_front();
          ck("d_rdata", d_rdata, e.data);
          ck("d_ready_cycle", 32'(cyc), 32'(e.cyc));
          $display("[TB] L%0d data done   cyc=%0d rdata=%h (exp %h @%0d)", LAT, cyc, d_rdata, e.data, e.cyc);
        end
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic issue_fetch(input logic [31:0] a, input logic [31:0] x, input int c);
      if_q.push_back('{x, c});
      if_req  = 1'b1;
      if_addr = a;
    endtask

    task automatic issue_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] x, input int c);
      d_q.push_back('{x, c});
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = a;
      d_wdata = wd;
    endtask

    task automatic wait_if();
      int k = 0;
      while (k < 200) begin
        @(negedge clk);
        if (if_ready) break;
        k++;
      end
      if (k == 200) ck("if_ready_timeout", 32'd0, 32'd1);
      tick();
      if_req = 1'b0;
    endtask

    task automatic wait_d();
      int k = 0;
      while (k < 200) begin
        @(negedge clk);
        if (d_ready) break;
        k++;
      end
      if (k == 200) ck("d_ready_timeout", 32'd0, 32'd1);
      tick();
      d_req = 1'b0;
    endtask

    initial begin
      rst = 1'b0; if_req = 1'b1; if_addr = 32'h4;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      last_load = '0;

      // Reset held two cycles with a fetch pending: nothing may happen.
      repeat (2) begin
        @(negedge clk);
        ck("rst_if_ready", 32'(if_ready), 32'd0);
        ck("rst_d_ready", 32'(d_ready), 32'd0);
        ck("rst_mem_en", 32'(mem_en), 32'd0);
        ck("rst_if_rdata", if_rdata, 32'd0);
        ck("rst_d_rdata", d_rdata, 32'd0);
      end

      // Single fetch issued the first cycle after reset release.
      tick();
      rst = 1'b1;
      n = cyc;
      if_q.push_back('{32'h2008_0005, n + LAT + 1});
      @(negedge clk);
      ck("fetch_mem_en", 32'(mem_en), 32'd1);
      ck("fetch_mem_we", 32'(mem_we), 32'd0);
      ck("fetch_mem_addr", mem_addr, 32'h4);
      ck("fetch_stall_n", 32'(stall), 32'd1);
      @(negedge clk);
      ck("fetch_mem_en_once", 32'(mem_en), 32'd0);
      ck("fetch_stall_n1", 32'(stall), 32'd1);
      wait_if();

      // Collision: load wins, fetch is granted after the load's DONE cycle.
      tick();
      n = cyc;
      issue_data(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, n + LAT + 1);
      issue_fetch(32'h8, 32'h0000_1111, n + 2 * LAT + 3);
      @(negedge clk);
      ck("coll_mem_addr", mem_addr, 32'h40);
      ck("coll_mem_we", 32'(mem_we), 32'd0);
      fork
        wait_d();
        wait_if();
      join
      last_load = 32'hDEAD_BEEF;

      // Store then load of the same address.
      tick();
      n = cyc;
      issue_data(1'b1, 32'h80, 32'h1234_5678, last_load, n + LAT + 1);
      @(negedge clk);
      ck("store_mem_en", 32'(mem_en), 32'd1);
      ck("store_mem_we", 32'(mem_we), 32'd1);
      ck("store_mem_addr", mem_addr, 32'h80);
      ck("store_mem_wdata", mem_wdata, 32'h1234_5678);
      @(negedge clk);
      ck("store_mem_we_once", 32'(mem_we), 32'd0);
      wait_d();
      tick();
      n = cyc;
      issue_data(1'b0, 32'h80, 32'h0, 32'h1234_5678, n + LAT + 1);
      wait_d();

      // Reset while BUSY: access abandoned, late read data ignored, no ready pulse.
      tick();
      if_req = 1'b1;
      if_addr = 32'hC;
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      if_req = 1'b0;
      last_load = '0;
      repeat (LAT + 3) begin
        @(negedge clk);
        ck("abort_if_ready", 32'(if_ready), 32'd0);
        ck("abort_if_rdata", if_rdata, 32'd0);
        ck("abort_mem_en", 32'(mem_en), 32'd0);
      end

      // Refetch of a word, then a store to it, then fetch again.
      tick();
      n = cyc;
      issue_fetch(32'h4, 32'h2008_0005, n + LAT + 1);
      wait_if();
      tick();
      n = cyc;
`ifdef MEM_PORT_ARBITER_IBUF_EN
      issue_fetch(32'h4, 32'h2008_0005, n + 1);
      @(negedge clk);
      ck("refetch_mem_en", 32'(mem_en), 32'd0);
`else
      issue_fetch(32'h4, 32'h2008_0005, n + LAT + 1);
      @(negedge clk);
      ck("refetch_mem_en", 32'(mem_en), 32'd1);
`endif
      wait_if();
      tick();
      n = cyc;
      issue_data(1'b1, 32'h4, 32'h5555_AAAA, last_load, n + LAT + 1);
      wait_d();
      tick();
      n = cyc;
      issue_fetch(32'h4, 32'h5555_AAAA, n + LAT + 1);
      @(negedge clk);
      ck("after_store_mem_en", 32'(mem_en), 32'd1);
      wait_if();

      repeat (3) @(negedge clk);
      ck("if_q_drained", 32'(if_q.size()), 32'd0);
      ck("d_q_drained", 32'(d_q.size()), 32'd0);
      fin = 1'b1;
    end
  end

  initial begin
    fork
      wait (g_lat[0].fin && g_lat[1].fin);
      #200000;
    join_any
    check("all_scenarios_done", {30'd0, g_lat[1].fin, g_lat[0].fin}, 32'd3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the CPU's fetch port and its load/store port.
- Sits between the mips core and a unified RAM.
- Serialises requests, with data having priority over fetch, and counts a fixed memory latency.
- Returns read data registered, with a one-cycle ready pulse, and drives a pipeline stall.

Parameters:
- MEM_LATENCY, 1: cycles from mem_en issue to mem_rdata valid; legal range 1..15.
- DATA_W, 32: data width of all data buses.
- ADDR_W, 32: byte address width of all address buses.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-low reset
- if_req  in  1  fetch request; held high until if_ready
- if_addr  in  ADDR_W  fetch byte address; held stable with if_req
- if_rdata  out  DATA_W  fetched instruction; valid when if_ready
- if_ready  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid when d_ready
- d_ready  out  1  one-cycle data completion pulse
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid MEM_LATENCY cycles after mem_en
- stall  out  1  (if_req & ~if_ready) | (d_req & ~d_ready), combinational

Behaviour:
- Reset: clk only; reset is synchronous and active-low (rst==0 at the edge).
  - State goes to IDLE; counter = 0; owner = FETCH.
  - if_rdata = d_rdata = 0; if_ready = d_ready = 0; mem_en = mem_we = 0.
  - Reset mid-access abandons the access; its late mem_rdata is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If d_req, grant DATA.
  - Else if if_req, grant FETCH.
  - Else stay in IDLE.
  - In the grant cycle, mem_en=1 (combinational); mem_addr/mem_we/mem_wdata come from the winner (mem_we=0 for fetch).
  - Record owner; counter=1; go to BUSY.
  - mem_en=0 and mem_we=0 in every non-grant cycle. mem_addr/mem_wdata are don't-care then.
- BUSY:
  - Increment the counter each cycle.
  - In the cycle counter==MEM_LATENCY, capture mem_rdata into the owner's rdata register (loads and fetches only), then go to DONE.
- DONE:
  - Pulse the owner's ready for exactly one cycle, then go to IDLE.
  - No grant is made in DONE, so the requester may drop req in the ready cycle without triggering a duplicate access.
- Latency: grant at cycle N; ready at N+MEM_LATENCY+1; next grant no earlier than N+MEM_LATENCY+2.
- Stores:
  - Same timing as loads.
  - d_rdata keeps its previous value.
- Simultaneous if_req and d_req in IDLE: data wins. Fetch is granted in the next IDLE cycle if if_req is still held.
- A request arriving while BUSY/DONE waits; stall stays high.
- Requests are never dropped or reordered. The non-owner's ready stays 0.
- Address/data pass through unmodified; no alignment checking.

Optional Feature:
- Macro: MEM_PORT_ARBITER_IBUF_EN.
- With the macro defined, a one-entry fetch buffer holds {valid, addr[ADDR_W-1:2], data}:
  - Filled on every completed fetch.
  - In IDLE, with no d_req, if if_req hits the buffer (valid and word address matches): no mem_en; go directly to DONE with if_rdata = buffered data, so if_ready arrives at N+1.
  - Invalidated by any granted store whose word address matches the tag, and by reset.
- Without the macro: no buffer; every fetch accesses memory.

Decomposition:
- Package mem_port_arbiter_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - owner enum {FETCH, DATA};
  - LAT_CNT_W = 4;
  - MEM_LATENCY_MAX = 15.
- One natural sub-module, mem_port_ibuf (the fetch buffer), instantiated only under MEM_PORT_ARBITER_IBUF_EN.

Test Plan:
- Reset then idle: rst=0 for 2 cycles with if_req=1 → if_ready=0, mem_en=0, if_rdata=0; first mem_en on the first cycle after rst=1.
- Single fetch, MEM_LATENCY=1: if_addr=0x0000_0004, memory returns 0x2008_0005 → mem_en one cycle at N, if_ready at N+2 with if_rdata=0x2008_0005; stall high N..N+1.
- Collision: if_req and d_req (load 0x40 → 0xDEAD_BEEF) both at N → mem_addr=0x40 at N, d_ready at N+2; fetch granted at N+3, if_ready at N+5.
- Store then load, MEM_LATENCY=3: store 0x1234_5678 to 0x80 → mem_we=1 for one cycle, d_ready at N+4; a subsequent load of 0x80 returns 0x1234_5678.
- Reset mid-access: rst=0 in the BUSY cycle → next cycle IDLE, no ready pulse, the late mem_rdata is not captured.
- With MEM_PORT_ARBITER_IBUF_EN: refetch 0x4 → if_ready at N+1, no mem_en; after a store to 0x4, the refetch goes to memory again.
